// File: rtl/sample_ring_bram.sv
// Ring buffer of the most recent DEPTH sensor samples with an age-indexed read port.
// Define RING_OVERWRITE_EN to let writes overwrite the oldest slot when full (adds ovf_cnt).
module sample_ring_bram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic [ADDR_W:0]   count,
`ifdef RING_OVERWRITE_EN
    output logic [7:0]        ovf_cnt,
`endif
    output logic              empty,
    output logic              full
);

    // Handshake: a sample transfers on a rising edge where wr_valid && wr_ready
    // are both high; clear on that edge discards it.
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   count_q;
    logic              rd_valid_q;
    logic              wr_accept;
    logic [ADDR_W-1:0] rd_slot;
    logic              rd_bad;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

`ifdef RING_OVERWRITE_EN
    assign wr_ready = !rst;
`else
    assign wr_ready = !full;
`endif

    assign wr_accept = wr_valid && wr_ready && !clear;
    // Power-of-two depth lets the age subtraction wrap for free.
    assign rd_slot   = wptr - ADDR_W'(1) - rd_idx;
    assign rd_bad    = ({1'b0, rd_idx} >= count_q);

    // A reset arriving while a response is registered suppresses that response.
    assign rd_valid  = rd_valid_q && !rst;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            count_q <= '0;
        end else if (clear) begin
            wptr    <= '0;
            count_q <= '0;
        end else if (wr_accept) begin
            wptr <= wptr + ADDR_W'(1);
            if (!full) begin
                count_q <= count_q + (ADDR_W + 1)'(1);
            end
        end
    end

`ifdef RING_OVERWRITE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (wr_accept && full && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`endif

    // Read-first: the memory read sees contents before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data    <= '0;
            rd_err     <= 1'b0;
        end else if (rd_req) begin
            rd_valid_q <= 1'b1;
            rd_err     <= rd_bad;
            rd_data    <= rd_bad ? '0 : mem[rd_slot];
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sample_ring_bram.sv
// Directed bench for sample_ring_bram at DEPTH=4; follows RING_OVERWRITE_EN when defined.
module tb_sample_ring_bram;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data = '0;
    logic              clear = 1'b0;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_idx = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
`ifdef RING_OVERWRITE_EN
    logic [7:0]        ovf_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sample_ring_bram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .clear    (clear),
        .rd_req   (rd_req),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .count    (count),
`ifdef RING_OVERWRITE_EN
        .ovf_cnt  (ovf_cnt),
`endif
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [DATA_W-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
`ifdef RING_OVERWRITE_EN
        n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ovf got %0d want 0", ovf_cnt); end
`endif
        rd_req = 1'b1; rd_idx = 2'd0;
        tick();
        rd_req = 1'b0;
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL empty_rd_valid got %b want 1", rd_valid); end
        n_checks++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL empty_rd_err got %b want 1", rd_err); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL empty_rd_data got %h want 0000", rd_data); end
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL empty_rd_valid_pulse got %b want 0", rd_valid); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_d [4];
        exp_d[0] = 16'h3333; exp_d[1] = 16'h2222; exp_d[2] = 16'h1111; exp_d[3] = 16'h0000;
        do_write(16'h1111);
        do_write(16'h2222);
        do_write(16'h3333);
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", count); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", empty); end
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; rd_idx = ADDR_W'(i);
            tick();
            n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid idx %0d got %b want 1", i, rd_valid); end
            n_checks++; if (rd_data !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data idx %0d got %h want %h", i, rd_data, exp_d[i]); end
            n_checks++; if (rd_err !== (i == 3)) begin n_fail++; $display("FAIL b2b_err idx %0d got %b want %b", i, rd_err, (i == 3)); end
        end
        rd_req = 1'b0;
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL b2b_hold_data got %h want 0000", rd_data); end
    endtask

    task automatic test_fill();
        logic [DATA_W-1:0] exp_d [4];
`ifdef RING_OVERWRITE_EN
        exp_d[0] = 16'h00A6; exp_d[1] = 16'h00A5; exp_d[2] = 16'h00A4; exp_d[3] = 16'h00A3;
`else
        exp_d[0] = 16'h00A4; exp_d[1] = 16'h00A3; exp_d[2] = 16'h00A2; exp_d[3] = 16'h00A1;
`endif
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            do_write(DATA_W'(16'h00A0 + i));
            if (i == 4) begin
`ifdef RING_OVERWRITE_EN
                n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_wr_ready got %b want 1", wr_ready); end
`else
                n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_wr_ready got %b want 0", wr_ready); end
`endif
            end
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", count); end
`ifdef RING_OVERWRITE_EN
        n_checks++; if (ovf_cnt !== 8'd2) begin n_fail++; $display("FAIL fill_ovf got %0d want 2", ovf_cnt); end
`endif
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; rd_idx = ADDR_W'(i);
            tick();
            n_checks++; if (rd_data !== exp_d[i] || rd_err !== 1'b0) begin
                n_fail++; $display("FAIL fill_read idx %0d got %h/%b want %h/0", i, rd_data, rd_err, exp_d[i]);
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_write_read_same_cycle();
        logic [DATA_W-1:0] exp_old;
        logic [DATA_W-1:0] exp_new;
`ifdef RING_OVERWRITE_EN
        exp_old = 16'h00A3; exp_new = 16'h00BB;
`else
        exp_old = 16'h00A1; exp_new = 16'h00A4;
`endif
        wr_valid = 1'b1; wr_data = 16'h00BB;
        rd_req = 1'b1; rd_idx = 2'd3;
        tick();
        wr_valid = 1'b0;
        n_checks++; if (rd_data !== exp_old) begin n_fail++; $display("FAIL rf_oldest got %h want %h", rd_data, exp_old); end
        rd_idx = 2'd0;
        tick();
        rd_req = 1'b0;
        n_checks++; if (rd_data !== exp_new) begin n_fail++; $display("FAIL rf_newest got %h want %h", rd_data, exp_new); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL rf_count got %0d want 4", count); end
`ifdef RING_OVERWRITE_EN
        n_checks++; if (ovf_cnt !== 8'd3) begin n_fail++; $display("FAIL rf_ovf got %0d want 3", ovf_cnt); end
`endif
    endtask

    task automatic test_clear();
        logic [DATA_W-1:0] exp_pre;
`ifdef RING_OVERWRITE_EN
        exp_pre = 16'h00BB;
`else
        exp_pre = 16'h00A4;
`endif
        clear = 1'b1; wr_valid = 1'b1; wr_data = 16'h00CC;
        rd_req = 1'b1; rd_idx = 2'd0;
        #1;
`ifdef RING_OVERWRITE_EN
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL clr_wr_ready got %b want 1", wr_ready); end
`else
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL clr_wr_ready got %b want 0", wr_ready); end
`endif
        tick();
        clear = 1'b0; wr_valid = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL clr_count got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %b want 1", empty); end
        n_checks++; if (rd_data !== exp_pre || rd_err !== 1'b0) begin
            n_fail++; $display("FAIL clr_pre_read got %h/%b want %h/0", rd_data, rd_err, exp_pre);
        end
`ifdef RING_OVERWRITE_EN
        n_checks++; if (ovf_cnt !== 8'd3) begin n_fail++; $display("FAIL clr_ovf_kept got %0d want 3", ovf_cnt); end
`endif
        tick();
        rd_req = 1'b0;
        n_checks++; if (rd_err !== 1'b1 || rd_data !== 16'h0000) begin
            n_fail++; $display("FAIL clr_post_read got %h/%b want 0000/1", rd_data, rd_err);
        end
        do_write(16'h00DD);
        rd_req = 1'b1; rd_idx = 2'd0;
        tick();
        n_checks++; if (rd_data !== 16'h00DD) begin n_fail++; $display("FAIL clr_first_write got %h want 00dd", rd_data); end
        rd_idx = 2'd1;
        tick();
        rd_req = 1'b0;
        n_checks++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL clr_dropped_word got err %b want 1", rd_err); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL clr_count_after got %0d want 1", count); end
    endtask

    task automatic test_rst_pending();
        do_write(16'h00E1);
        rd_req = 1'b1; rd_idx = 2'd0;
        tick();
        rd_req = 1'b0; rst = 1'b1;
        #1;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pending_valid got %b want 0", rd_valid); end
        tick();
        rst = 1'b0;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after_valid got %b want 0", rd_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
        n_checks++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL rst_rd_data got %h want 0000", rd_data); end
`ifdef RING_OVERWRITE_EN
        n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_ovf got %0d want 0", ovf_cnt); end
`endif
        do_write(16'h00F1);
        do_write(16'h00F2);
        rd_req = 1'b1; rd_idx = 2'd1;
        tick();
        rd_req = 1'b0;
        n_checks++; if (rd_data !== 16'h00F1) begin n_fail++; $display("FAIL rst_rewrite got %h want 00f1", rd_data); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fill();
        test_write_read_same_cycle();
        test_clear();
        test_rst_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_ring_bram.md
# sample_ring_bram

Parametrised block-RAM ring buffer holding the most recent DEPTH sensor samples (DHT11 humidity/temperature words) with a valid/ready write side and an age-indexed read port. It sits between the DHT11 frame decoder (writer) and the IoT report/UART formatter (reader), replacing the single-word holding RAM. Storage is inferred as iCE40 EBR; control state is in fabric.

## Interface
- DATA_W, 16, sample word width
- DEPTH, 32, number of slots; power of two, 2..256
- ADDR_W, $clog2(DEPTH), slot index width (derived, not overridden)

- clk  in  1  single clock domain, rising edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  writer presents a sample
- wr_ready  out  1  block accepts a sample this cycle
- wr_data  in  DATA_W  sample word
- clear  in  1  synchronous flush pulse
- rd_req  in  1  read request, single-cycle pulse
- rd_idx  in  ADDR_W  age index: 0 = newest, count-1 = oldest
- rd_valid  out  1  read response pulse
- rd_data  out  DATA_W  read word; 0 when rd_err
- rd_err  out  1  rd_idx was >= count at request
- count  out  ADDR_W+1  samples stored, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- ovf_cnt  out  8  overwritten-sample counter (present only with overwrite macro)

## Operation
- State: wptr (ADDR_W, next slot to write), count (ADDR_W+1), memory mem[0:DEPTH-1], registered read outputs.
- Reset: wptr=0, count=0, rd_valid=0, rd_data=0, rd_err=0, ovf_cnt=0; empty=1, full=0; wr_ready=1. Memory contents not reset/initialised.
- Write accept = wr_valid && wr_ready && !clear: mem[wptr] <= wr_data; wptr <= wptr+1 (wraps DEPTH-1 -> 0); count <= min(count+1, DEPTH).
- Read: on rd_req, slot = (wptr - 1 - rd_idx) mod DEPTH using pre-edge wptr; rd_err = (rd_idx >= count) using pre-edge count.
- Memory is read-first: a read of the slot written the same edge returns old contents.
- clear: wptr <= 0, count <= 0 next cycle; wins over a same-cycle write (write dropped, wr_ready still shows its normal value); same-cycle read uses pre-clear state. ovf_cnt not cleared by clear, only by rst.
- rst mid-operation: pending rd_req dropped (no rd_valid next cycle); all state to reset values.
- empty, full, count, wr_ready are combinational from registered count; no extra latency.

## Timing
- Write: accepted sample visible to a read requested the next cycle (count/wptr update at the accepting edge).
- Read latency 1: rd_req at edge N -> rd_valid=1 with rd_data/rd_err for exactly the cycle after edge N+1 sampling; back-to-back rd_req every cycle yields rd_valid every cycle.
- rd_data holds its last value when rd_valid=0; on rd_err, rd_data=0.
- Simultaneous write and read: read observes pre-write buffer (newest = previous sample).

## Configuration
- RING_OVERWRITE_EN defined: wr_ready=1 whenever not in reset; write when full overwrites oldest slot, count stays DEPTH, ovf_cnt increments (saturates at 255).
- RING_OVERWRITE_EN undefined: wr_ready = !full; writes stall when full; ovf_cnt port absent.

## Test plan
- DEPTH=4, after reset: count=0, empty=1, wr_ready=1; rd_req idx 0 -> rd_valid next cycle, rd_err=1, rd_data=0.
- Write 0x1111,0x2222,0x3333: count=3; reads idx 0,1,2 back-to-back -> 0x3333,0x2222,0x1111 on consecutive cycles; idx 3 -> rd_err=1.
- Write 0xA1..0xA6 with macro on: full=1, count=4, ovf_cnt=2; idx 0..3 -> 0xA6,0xA5,0xA4,0xA3. Macro off: wr_ready=0 after 0xA4, idx 0 -> 0xA4.
- Full with macro on, write 0xBB and rd_req idx 3 same cycle -> rd_data = old oldest (read-first), then idx 0 -> 0xBB.
- clear with wr_valid same cycle: count=0 next cycle, written word not stored; rd_req same cycle returns pre-clear data.
- rst asserted the cycle after rd_req: no rd_valid pulse; count=0, wptr=0 afterwards.
